// File: rtl/tx_iq_buf.sv
// tx_iq_buf: elastic IQ sample buffer between dot11_tx and the DAC interface.
// Samples are queued in a FIFO until START_LEVEL entries are held (or the
// packet ends early). Then one sample is played per dac_strobe. The block
// flags starvation as a sticky underrun, drains on tx_end and pulses buf_done
// once the last sample has left.
// Optional feature: define TX_IQ_BUF_GAIN_EN to add the gain_shift port.
// Each popped sample is then arithmetically left-shifted by 0..3 and saturated.

module tx_iq_buf #(
    parameter int DEPTH_LOG2  = 6,
    parameter int START_LEVEL = 16,
    parameter int IQ_WIDTH    = 16
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       iq_in_valid,
    input  logic signed [IQ_WIDTH-1:0] iq_in_i,
    input  logic signed [IQ_WIDTH-1:0] iq_in_q,
    output logic                       iq_in_ready,
    input  logic                       tx_end,
    input  logic                       dac_strobe,
`ifdef TX_IQ_BUF_GAIN_EN
    input  logic [1:0]                 gain_shift,
`endif
    output logic signed [IQ_WIDTH-1:0] dac_i,
    output logic signed [IQ_WIDTH-1:0] dac_q,
    output logic                       dac_valid,
    output logic [DEPTH_LOG2:0]        fifo_level,
    output logic                       underrun,
    output logic                       buf_done
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    localparam logic [DEPTH_LOG2:0]   LVL_FULL  = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LVL_START = (DEPTH_LOG2 + 1)'(START_LEVEL);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_STREAM,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   level;
    logic [DEPTH_LOG2:0]   level_nxt;
    logic [2*IQ_WIDTH-1:0] mem [DEPTH];

    logic end_seen;
    logic push;
    logic pop;
    logic fifo_empty;
    logic end_now;
    logic starve;
    logic enter_idle;
    logic enter_done;

    logic signed [IQ_WIDTH-1:0] head_i;
    logic signed [IQ_WIDTH-1:0] head_q;
    logic signed [IQ_WIDTH-1:0] out_i;
    logic signed [IQ_WIDTH-1:0] out_q;

    assign fifo_level = level;
    assign buf_done   = (state == S_DONE);

    // Handshake and FIFO status, all derived from the registered level.
    always_comb begin
        iq_in_ready = (level != LVL_FULL);
        push        = iq_in_valid && iq_in_ready;
        fifo_empty  = (level == '0);
        // A tx_end in the same cycle counts as already seen. An empty strobe
        // coinciding with the end of the packet then drains instead of
        // flagging an underrun.
        end_now     = end_seen || tx_end;
        // A push into an empty FIFO is not visible to a strobe in the same
        // cycle. That strobe therefore starves, and the sample waits.
        pop         = (state == S_STREAM) && dac_strobe && !fifo_empty;
        starve      = (state == S_STREAM) && dac_strobe && fifo_empty && !end_now;
    end

    // Occupancy after this cycle's push/pop; a simultaneous pair cancels.
    always_comb begin
        level_nxt = level;
        if (push && !pop) begin
            level_nxt = level + LVL_ONE;
        end else if (pop && !push) begin
            level_nxt = level - LVL_ONE;
        end
    end

    // Next-state logic for the fill / stream / drain sequence.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can
        // leave it unassigned and infer a latch.
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                // A sample pushed during the DONE cycle is still a packet.
                if (push || !fifo_empty) begin
                    state_nxt = S_FILL;
                end else if (tx_end) begin
                    state_nxt = S_DONE;
                end
            end
            S_FILL: begin
                // No pops here, so level_nxt is the level entering the next
                // cycle. Use it so streaming starts right after the last
                // needed push.
                if (level_nxt >= LVL_START || (end_now && level_nxt != '0)) begin
                    state_nxt = S_STREAM;
                end else if (end_now) begin
                    state_nxt = S_DONE;
                end
            end
            S_STREAM: begin
                if (dac_strobe && fifo_empty && end_now) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign enter_idle = (state_nxt == S_IDLE) && (state != S_IDLE);
    assign enter_done = (state_nxt == S_DONE) && (state != S_DONE);

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments only. All
        // flops then sample the pre-edge values, whatever the order of the
        // always blocks.
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            level <= level_nxt;
        end
    end

    // Sample storage.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset. Clearing the pointers and the
        // level on reset already makes every stale entry unreachable.
        if (push) begin
            mem[wr_ptr] <= {iq_in_i, iq_in_q};
        end
    end

    assign {head_i, head_q} = mem[rd_ptr];

`ifdef TX_IQ_BUF_GAIN_EN
    // Arithmetic left shift by sh. The result saturates when the bits above
    // the new sign bit disagree with it.
    function automatic logic signed [IQ_WIDTH-1:0] shift_sat(
        input logic signed [IQ_WIDTH-1:0] x,
        input logic [1:0]                 sh
    );
        logic signed [IQ_WIDTH+2:0] wide;
        logic [3:0]                 top;
        wide = (IQ_WIDTH + 3)'(x);
        wide = wide <<< sh;
        top  = wide[IQ_WIDTH+2 -: 4];
        if (top == 4'b0000 || top == 4'b1111) begin
            return wide[IQ_WIDTH-1:0];
        end else if (wide[IQ_WIDTH+2]) begin
            return {1'b1, {(IQ_WIDTH-1){1'b0}}};
        end else begin
            return {1'b0, {(IQ_WIDTH-1){1'b1}}};
        end
    endfunction

    // Scaled head sample, ready to be registered on a pop.
    always_comb begin
        out_i = shift_sat(head_i, gain_shift);
        out_q = shift_sat(head_q, gain_shift);
    end
`else
    // Head sample passes through unmodified.
    always_comb begin
        out_i = head_i;
        out_q = head_q;
    end
`endif

    // DAC output register. Updates on a pop, zeroes on starvation or on
    // entering DONE, and holds otherwise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dac_i     <= '0;
            dac_q     <= '0;
            dac_valid <= 1'b0;
        end else begin
            dac_valid <= pop;
            if (pop) begin
                dac_i <= out_i;
                dac_q <= out_q;
            end else if (starve || enter_done) begin
                dac_i <= '0;
                dac_q <= '0;
            end
        end
    end

    // Sticky underrun and end-of-packet flags, both cleared on entering IDLE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            underrun <= 1'b0;
            end_seen <= 1'b0;
        end else begin
            if (enter_idle) begin
                underrun <= 1'b0;
            end else if (starve) begin
                underrun <= 1'b1;
            end
            if (enter_idle) begin
                end_seen <= 1'b0;
            end else if (tx_end && state != S_DONE) begin
                end_seen <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tx_iq_buf.sv
// tb_tx_iq_buf: self-checking bench for tx_iq_buf.
// The bench uses a per-cycle vector table for a short packet. Hand-written
// sequences cover pre-fill, backpressure, underrun, reset mid-packet and
// (with TX_IQ_BUF_GAIN_EN) gain saturation. Every accepted sample goes into a
// scoreboard queue and is compared when dac_valid is seen.

module tb_tx_iq_buf;

    localparam int DEPTH_LOG2  = 6;
    localparam int START_LEVEL = 16;
    localparam int IQ_WIDTH    = 16;
    localparam int GAIN        = 2;

    logic                       clk = 1'b0;
    logic                       rstn = 1'b0;
    logic                       iq_in_valid = 1'b0;
    logic signed [IQ_WIDTH-1:0] iq_in_i = '0;
    logic signed [IQ_WIDTH-1:0] iq_in_q = '0;
    logic                       iq_in_ready;
    logic                       tx_end = 1'b0;
    logic                       dac_strobe = 1'b0;
    logic signed [IQ_WIDTH-1:0] dac_i;
    logic signed [IQ_WIDTH-1:0] dac_q;
    logic                       dac_valid;
    logic [DEPTH_LOG2:0]        fifo_level;
    logic                       underrun;
    logic                       buf_done;
`ifdef TX_IQ_BUF_GAIN_EN
    logic [1:0]                 gain_shift = 2'(GAIN);
`endif

    tx_iq_buf #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .START_LEVEL(START_LEVEL),
        .IQ_WIDTH   (IQ_WIDTH)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .iq_in_valid(iq_in_valid),
        .iq_in_i    (iq_in_i),
        .iq_in_q    (iq_in_q),
        .iq_in_ready(iq_in_ready),
        .tx_end     (tx_end),
        .dac_strobe (dac_strobe),
`ifdef TX_IQ_BUF_GAIN_EN
        .gain_shift (gain_shift),
`endif
        .dac_i      (dac_i),
        .dac_q      (dac_q),
        .dac_valid  (dac_valid),
        .fifo_level (fifo_level),
        .underrun   (underrun),
        .buf_done   (buf_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int i;
        int q;
    } sample_t;

    typedef struct {
        bit vld;
        int i;
        int q;
        bit end_p;
        bit strb;
        int lvl;
        bit rdy;
        bit dvld;
        bit done;
        bit und;
    } vec_t;

    int      n_tests = 0;
    int      n_fail  = 0;
    bit      last_acc;
    sample_t sb[$];

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference gain model: multiply and clamp, independent of bit tricks.
    function automatic int model_gain(input int x);
`ifdef TX_IQ_BUF_GAIN_EN
        int v;
        v = x * (1 << GAIN);
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
        return v;
`else
        return x;
`endif
    endfunction

    // One clock. Record an accepted push before the edge and sample 1 ns
    // after it. Any dac_valid is compared with the scoreboard head.
    task automatic step();
        last_acc = iq_in_valid && iq_in_ready;
        if (last_acc) sb.push_back('{model_gain(int'(iq_in_i)), model_gain(int'(iq_in_q))});
        @(posedge clk);
        #1;
        if (dac_valid) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected dac_valid: got i=%0d q=%0d, expected no output", dac_i, dac_q);
            end else begin
                sample_t e;
                e = sb.pop_front();
                check("scoreboard dac_i", dac_i, e.i);
                check("scoreboard dac_q", dac_q, e.q);
            end
        end
    endtask

    task automatic push_one(input int i, input int q);
        iq_in_valid = 1'b1;
        iq_in_i     = 16'(i);
        iq_in_q     = 16'(q);
        step();
        iq_in_valid = 1'b0;
    endtask

    // Strobe every cycle until buf_done (bounded), then check the drain state.
    task automatic drain(input string name, input bit exp_und);
        bit seen;
        seen = 1'b0;
        dac_strobe = 1'b1;
        for (int c = 0; c < 300 && !seen; c++) begin
            step();
            if (buf_done) seen = 1'b1;
        end
        dac_strobe = 1'b0;
        check({name, " buf_done reached"}, seen, 1);
        check({name, " dac_i zero at done"}, dac_i, 0);
        check({name, " dac_q zero at done"}, dac_q, 0);
        check({name, " underrun at done"}, underrun, exp_und);
        check({name, " all samples played"}, sb.size(), 0);
        step();
        check({name, " buf_done single pulse"}, buf_done, 0);
        check({name, " underrun cleared in idle"}, underrun, 0);
    endtask

    function automatic vec_t mk(bit v, int i, int q, bit e, bit s, int lvl, bit dv, bit dn, bit un);
        return '{v, i, q, e, s, lvl, 1'b1, dv, dn, un};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[17];
        int   k;

        // Short packet: 5 samples, tx_end, playout, DONE; then tx_end on empty IDLE.
        vt[0]  = mk(1, 100, -100, 0, 0, 1, 0, 0, 0);
        vt[1]  = mk(1, 101, -101, 0, 0, 2, 0, 0, 0);
        vt[2]  = mk(1, 102, -102, 0, 0, 3, 0, 0, 0);
        vt[3]  = mk(1, 103, -103, 0, 0, 4, 0, 0, 0);
        vt[4]  = mk(1, 104, -104, 0, 0, 5, 0, 0, 0);
        vt[5]  = mk(0, 0, 0, 1, 0, 5, 0, 0, 0);
        vt[6]  = mk(0, 0, 0, 0, 0, 5, 0, 0, 0);
        vt[7]  = mk(0, 0, 0, 0, 1, 4, 1, 0, 0);
        vt[8]  = mk(0, 0, 0, 0, 0, 4, 0, 0, 0);
        vt[9]  = mk(0, 0, 0, 0, 1, 3, 1, 0, 0);
        vt[10] = mk(0, 0, 0, 0, 1, 2, 1, 0, 0);
        vt[11] = mk(0, 0, 0, 0, 1, 1, 1, 0, 0);
        vt[12] = mk(0, 0, 0, 0, 1, 0, 1, 0, 0);
        vt[13] = mk(0, 0, 0, 0, 1, 0, 0, 1, 0);
        vt[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        vt[15] = mk(0, 0, 0, 1, 0, 0, 0, 1, 0);
        vt[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset fifo_level", fifo_level, 0);
        check("reset iq_in_ready", iq_in_ready, 1);
        check("reset dac_i", dac_i, 0);
        check("reset dac_q", dac_q, 0);
        check("reset dac_valid", dac_valid, 0);
        check("reset underrun", underrun, 0);
        check("reset buf_done", buf_done, 0);
        rstn = 1'b1;
        step();

        // Table-driven short packet.
        for (int r = 0; r < 17; r++) begin
            iq_in_valid = vt[r].vld;
            iq_in_i     = 16'(vt[r].i);
            iq_in_q     = 16'(vt[r].q);
            tx_end      = vt[r].end_p;
            dac_strobe  = vt[r].strb;
            step();
            check($sformatf("vec%0d fifo_level", r), fifo_level, vt[r].lvl);
            check($sformatf("vec%0d iq_in_ready", r), iq_in_ready, vt[r].rdy);
            check($sformatf("vec%0d dac_valid", r), dac_valid, vt[r].dvld);
            check($sformatf("vec%0d buf_done", r), buf_done, vt[r].done);
            check($sformatf("vec%0d underrun", r), underrun, vt[r].und);
        end
        iq_in_valid = 1'b0;
        tx_end      = 1'b0;
        dac_strobe  = 1'b0;
        check("short packet scoreboard empty", sb.size(), 0);

        // Pre-fill: a strobe alongside the 16th push is ignored (still FILL).
        for (int j = 0; j < 15; j++) push_one(j, -j);
        dac_strobe = 1'b1;
        push_one(15, -15);
        dac_strobe = 1'b0;
        check("prefill level after 16 pushes", fifo_level, 16);
        check("prefill no output while filling", dac_valid, 0);
        step();
        dac_strobe = 1'b1;
        step();
        dac_strobe = 1'b0;
        check("prefill first dac_valid", dac_valid, 1);
        check("prefill first dac_i", dac_i, 0);
        check("prefill first dac_q", dac_q, 0);
        check("prefill level after pop", fifo_level, 15);
        tx_end = 1'b1;
        step();
        tx_end = 1'b0;
        drain("prefill", 1'b0);

        // Backpressure: source offers 70 samples and holds each until accepted.
        k = 0;
        for (int c = 0; c < 80; c++) begin
            iq_in_valid = (k < 70);
            iq_in_i     = 16'(500 + k);
            iq_in_q     = 16'(-(500 + k));
            step();
            if (last_acc) k++;
        end
        check("backpressure accepted before strobes", k, 64);
        check("backpressure level full", fifo_level, 64);
        check("backpressure ready low when full", iq_in_ready, 0);
        dac_strobe = 1'b1;
        for (int c = 0; c < 200 && k < 70; c++) begin
            iq_in_valid = 1'b1;
            iq_in_i     = 16'(500 + k);
            iq_in_q     = 16'(-(500 + k));
            step();
            if (last_acc) k++;
        end
        iq_in_valid = 1'b0;
        dac_strobe  = 1'b0;
        check("backpressure all 70 accepted", k, 70);
        tx_end = 1'b1;
        step();
        tx_end = 1'b0;
        drain("backpressure", 1'b0);

        // Underrun: 16 samples, 16 strobes. A 17th strobe with a same-cycle push
        // into the empty FIFO flags underrun; that sample plays on the next strobe.
        for (int j = 0; j < 16; j++) push_one(200 + j, -(200 + j));
        step();
        dac_strobe = 1'b1;
        repeat (16) step();
        check("underrun clear after 16 strobes", underrun, 0);
        check("underrun level empty", fifo_level, 0);
        iq_in_valid = 1'b1;
        iq_in_i     = 16'(300);
        iq_in_q     = 16'(-300);
        step();
        iq_in_valid = 1'b0;
        check("underrun set on 17th strobe", underrun, 1);
        check("underrun dac_i zeroed", dac_i, 0);
        check("underrun dac_q zeroed", dac_q, 0);
        check("underrun dac_valid low", dac_valid, 0);
        check("underrun pushed sample kept", fifo_level, 1);
        step();
        dac_strobe = 1'b0;
        check("underrun late sample played", dac_valid, 1);
        repeat (3) step();
        check("underrun sticky", underrun, 1);
        tx_end = 1'b1;
        step();
        tx_end = 1'b0;
        drain("underrun", 1'b1);

        // Reset mid-packet with 30 samples buffered in STREAM.
        for (int j = 0; j < 31; j++) push_one(1000 + j, -(1000 + j));
        step();
        dac_strobe = 1'b1;
        step();
        dac_strobe = 1'b0;
        check("midreset level before reset", fifo_level, 30);
        check("midreset dac_valid before reset", dac_valid, 1);
        #2;
        rstn = 1'b0;
        #1;
        check("midreset fifo_level", fifo_level, 0);
        check("midreset iq_in_ready", iq_in_ready, 1);
        check("midreset dac_i", dac_i, 0);
        check("midreset dac_q", dac_q, 0);
        check("midreset dac_valid", dac_valid, 0);
        check("midreset buf_done", buf_done, 0);
        sb.delete();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        tx_end = 1'b1;
        step();
        tx_end = 1'b0;
        check("midreset idle then tx_end gives done", buf_done, 1);
        step();
        check("midreset done single pulse", buf_done, 0);

`ifdef TX_IQ_BUF_GAIN_EN
        // Gain: shift by 2 with saturation on both rails.
        push_one(10000, -3000);
        push_one(-20000, 100);
        tx_end = 1'b1;
        step();
        tx_end = 1'b0;
        step();
        dac_strobe = 1'b1;
        step();
        check("gain dac_i saturates high", dac_i, 32767);
        check("gain dac_q scaled", dac_q, -12000);
        step();
        dac_strobe = 1'b0;
        check("gain dac_i saturates low", dac_i, -32768);
        check("gain dac_q small scaled", dac_q, 400);
        drain("gain", 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
